// File: rtl/uart_rx_baud_generator_pkg.sv
// Shared eUSCI definitions for the receive baud-rate generator.
//  - BRG state encoding
//  - OS16 tick count / mid-tick, minimum LF bit period
//  - brgCfg_t: configuration captured at frame start
//  - phaseLen(): length of the next prescaler run (one LF half-bit or one OS16 tick)
package eusci_pkg;

  typedef enum logic {
    BRG_IDLE = 1'b0,
    BRG_RUN  = 1'b1
  } brgState_t;

  localparam int OS16_TICKS    = 16;
  localparam int OS16_MID      = 8;
  localparam int LF_MIN_PERIOD = 2;

  typedef struct packed {
    logic        os16;
    logic [15:0] brw;
    logic [3:0]  brf;
    logic [7:0]  brs;
  } brgCfg_t;

  // Prescaler run length = base + addOne cycles; base is never 0.
  typedef struct packed {
    logic [15:0] base;
    logic        addOne;
  } phaseLen_t;

  // tick: OS16 tick index 0..15. In LF mode only two phases exist and they
  // reuse the same field: 0 = low half of the bit, OS16_MID = high half.
  function automatic phaseLen_t phaseLen(brgCfg_t cfg, logic [2:0] idx, logic [3:0] tick);
    phaseLen_t   p;
    logic [16:0] n;
    p = '0;
    n = '0;
    if (cfg.os16) begin
      p.base   = (cfg.brw == 16'd0) ? 16'd1 : cfg.brw;
      p.addOne = (tick < cfg.brf) || ((tick == 4'(OS16_TICKS - 1)) && cfg.brs[idx]);
    end else begin
      // 17-bit sum: BRW=FFFF plus BRS bit gives 65536 without wrapping.
      n = {1'b0, cfg.brw} + {16'd0, cfg.brs[idx]};
      if (n < 17'(LF_MIN_PERIOD)) n = 17'(LF_MIN_PERIOD);
      // Both halves are <= 32768, so they fit the 16-bit base.
      if (tick >= 4'(OS16_MID)) p.base = 16'(n - (n >> 1));
      else                      p.base = 16'(n >> 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_baud_generator_if.sv
// Bus between the receive baud-rate generator and the receive state machine.
//  config : wUCOS16, wUCBRW, wUCBRF, wUCBRS (sampled at frame start)
//  line   : Rx (async, idle high)
//  status : RxBusy (receiver frame in progress)
//  clock  : BITCLK, BitStart, BitSample, BRBusy (generator outputs)
// master = the generator, slave = the receiver / register side.
interface uart_rx_baud_generator_if;
  logic        wUCOS16;
  logic [15:0] wUCBRW;
  logic [3:0]  wUCBRF;
  logic [7:0]  wUCBRS;
  logic        Rx;
  logic        RxBusy;
  logic        BITCLK;
  logic        BitStart;
  logic        BitSample;
  logic        BRBusy;

  modport master (
    input  wUCOS16, wUCBRW, wUCBRF, wUCBRS, Rx, RxBusy,
    output BITCLK, BitStart, BitSample, BRBusy
  );

  modport slave (
    output wUCOS16, wUCBRW, wUCBRF, wUCBRS, Rx, RxBusy,
    input  BITCLK, BitStart, BitSample, BRBusy
  );
endinterface

// File: rtl/uart_rx_baud_generator_prescaler.sv
// brg_prescaler: loadable down-counter timing one LF half-bit or one OS16 tick.
//  MCLK, reset : clock, synchronous active-low reset
//  enable      : count and report terminal
//  load        : start a new run of (base + addOne) cycles; wins over counting
//  base        : run length, must be >= 1
//  addOne      : +1 cycle modulation
//  terminal    : high in the last cycle of a run
// A run loaded at edge X reports terminal before edge X + length.
module brg_prescaler (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] base,
  input  logic        addOne,
  output logic        terminal
);
  // Extra bit keeps base=FFFF plus addOne (65536 cycles) representable.
  logic [16:0] cnt;

  always_ff @(posedge MCLK) begin
    if (!reset)                       cnt <= '0;
    else if (load)                    cnt <= {1'b0, base} + {16'd0, addOne} - 17'd1;
    else if (enable && cnt != 17'd0)  cnt <= cnt - 17'd1;
  end

  assign terminal = enable && (cnt == 17'd0);
endmodule

// File: rtl/uart_rx_baud_generator.sv
// uart_rx_baud_generator: eUSCI UART receive-side bit clock generator.
// Detects the start-bit fall on Rx and produces BITCLK aligned to it:
// BITCLK falls at each bit start, rises at mid-bit where the receiver samples.
//  MCLK, reset : clock, synchronous active-low reset
//  bus.master  : config in, Rx/RxBusy in, BITCLK/BitStart/BitSample/BRBusy out
module uart_rx_baud_generator
  import eusci_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                          MCLK,
  input  logic                          reset,
  uart_rx_baud_generator_if.master      bus
);

  logic [SYNC_STAGES-1:0] rxSync;
  logic [SYNC_STAGES-1:0] flushPipe;
  logic                   rxPrev, armed, startEdge;

  brgState_t  state, stateNext;
  brgCfg_t    cfgLat, cfgLive, cfgEff;
  phaseLen_t  nextLen;
  logic [2:0] idx, idxNext;
  logic [3:0] tick, tickNext;
  logic       firstBit, firstBitNext;
  logic       bitClk, bitStart, bitSample;
  logic       bitClkNext, bitStartNext, bitSampleNext;
  logic       load, terminal, lastPhase;

  // Synchronizer and start-edge detector. The detector arms only in IDLE and
  // takes one IDLE cycle to re-arm, so a line already low (break) when a frame
  // ends is not mistaken for a new start. After reset it also waits until the
  // reset-loaded ones have left the synchronizer.
  always_ff @(posedge MCLK) begin
    if (!reset) begin
      rxSync    <= '1;
      rxPrev    <= 1'b1;
      flushPipe <= '0;
      armed     <= 1'b0;
    end else begin
      rxSync    <= {rxSync[SYNC_STAGES-2:0], bus.Rx};
      rxPrev    <= rxSync[SYNC_STAGES-1];
      flushPipe <= {flushPipe[SYNC_STAGES-2:0], 1'b1};
      if (state == BRG_RUN)               armed <= 1'b0;
      else if (flushPipe[SYNC_STAGES-1])  armed <= 1'b1;
    end
  end

  assign startEdge = (state == BRG_IDLE) && armed && rxPrev && !rxSync[SYNC_STAGES-1];

  assign cfgLive = '{os16: bus.wUCOS16, brw: bus.wUCBRW, brf: bus.wUCBRF, brs: bus.wUCBRS};
  // The first run is loaded on the start edge, before cfgLat holds the new value.
  assign cfgEff  = (state == BRG_IDLE) ? cfgLive : cfgLat;

  assign lastPhase = cfgLat.os16 ? (tick == 4'(OS16_TICKS - 1)) : (tick >= 4'(OS16_MID));

  always_comb begin
    stateNext     = state;
    tickNext      = tick;
    idxNext       = idx;
    firstBitNext  = firstBit;
    bitClkNext    = bitClk;
    bitStartNext  = 1'b0;
    bitSampleNext = 1'b0;
    load          = 1'b0;
    case (state)
      BRG_IDLE: begin
        if (startEdge) begin
          stateNext    = BRG_RUN;
          tickNext     = '0;
          idxNext      = '0;
          firstBitNext = 1'b1;
          bitClkNext   = 1'b0;
          bitStartNext = 1'b1;
          load         = 1'b1;
        end
      end
      BRG_RUN: begin
        if (terminal) begin
          if (!lastPhase) begin
            // LF jumps straight to the high half; OS16 walks the ticks.
            tickNext = cfgLat.os16 ? tick + 4'd1 : 4'(OS16_MID);
            load     = 1'b1;
            if (tickNext == 4'(OS16_MID)) begin
              bitClkNext    = 1'b1;
              bitSampleNext = 1'b1;
            end
          end else if (!bus.RxBusy && !firstBit) begin
            // Start bit always completes: RxBusy only rises after its sample.
            stateNext  = BRG_IDLE;
            bitClkNext = 1'b1;
          end else begin
            tickNext     = '0;
            idxNext      = idx + 3'd1;
            firstBitNext = 1'b0;
            bitClkNext   = 1'b0;
            bitStartNext = 1'b1;
            load         = 1'b1;
          end
        end
      end
      default: stateNext = BRG_IDLE;
    endcase
    nextLen = phaseLen(cfgEff, idxNext, tickNext);
  end

  brg_prescaler uPrescaler (
    .MCLK     (MCLK),
    .reset    (reset),
    .enable   (state == BRG_RUN),
    .load     (load),
    .base     (nextLen.base),
    .addOne   (nextLen.addOne),
    .terminal (terminal)
  );

  always_ff @(posedge MCLK) begin
    if (!reset) begin
      state     <= BRG_IDLE;
      tick      <= '0;
      idx       <= '0;
      firstBit  <= 1'b0;
      cfgLat    <= '0;
      bitClk    <= 1'b1;
      bitStart  <= 1'b0;
      bitSample <= 1'b0;
    end else begin
      state     <= stateNext;
      tick      <= tickNext;
      idx       <= idxNext;
      firstBit  <= firstBitNext;
      bitClk    <= bitClkNext;
      bitStart  <= bitStartNext;
      bitSample <= bitSampleNext;
      if (startEdge) cfgLat <= cfgLive;
    end
  end

  assign bus.BITCLK    = bitClk;
  assign bus.BitStart  = bitStart;
  assign bus.BitSample = bitSample;
  assign bus.BRBusy    = (state == BRG_RUN);

endmodule

// File: tb/tb_uart_rx_baud_generator.sv
module tb_uart_rx_baud_generator;
  localparam int S = 2;

  logic MCLK  = 1'b0;
  logic reset = 1'b0;
  logic rxBusyDrv = 1'b0;

  uart_rx_baud_generator_if bus();
  assign bus.RxBusy = rxBusyDrv;

  uart_rx_baud_generator #(.SYNC_STAGES(S)) dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  int nPass  = 0;
  int nCheck = 0;
  int cyc    = 0;
  bit checkEn = 0;
  int busyLimit = 3;
  int fs = 0;
  int startQ[$];
  int sampQ[$];

  task automatic check(input string name, input longint act, input longint exp);
    nCheck++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit       mRun = 0, mIdleFirst = 0, mBitClk = 1, mStart = 0, mSample = 0, mFirst = 0;
  int       mIdx = 0, mC = 0, mLow = 0, mLen = 0;
  bit       mOs = 0;
  int       mBrw = 0, mBrf = 0;
  bit [7:0] mBrs = 0;
  bit       rxH[8];
  bit       rxV[8];

  task automatic calcLens(input int i);
    int n, t;
    if (!mOs) begin
      n = mBrw + int'(mBrs[i]);
      if (n < 2) n = 2;
      mLen = n;
      mLow = n / 2;
    end else begin
      mLen = 0;
      mLow = 0;
      for (int k = 0; k < 16; k++) begin
        t = (mBrw == 0) ? 1 : mBrw;
        if (k < mBrf) t++;
        if (k == 15 && mBrs[i]) t++;
        mLen += t;
        if (k < 8) mLow += t;
      end
    end
  endtask

  always @(posedge MCLK) begin
    bit fall;
    cyc++;
    // A start needs a real 1 then 0 on the line, seen through the synchronizer.
    fall = rxV[S-1] && rxV[S] && rxH[S] && !rxH[S-1];
    mStart  = 0;
    mSample = 0;
    if (!reset) begin
      mRun = 0; mIdleFirst = 0; mBitClk = 1;
    end else if (!mRun) begin
      if (mIdleFirst) mIdleFirst = 0;
      else if (fall) begin
        mRun = 1; mOs = bus.wUCOS16; mBrw = int'(bus.wUCBRW); mBrf = int'(bus.wUCBRF);
        mBrs = bus.wUCBRS; mIdx = 0; mFirst = 1; mC = 0; calcLens(0);
        mBitClk = 0; mStart = 1;
      end
    end else begin
      mC++;
      if (mC == mLow) begin mBitClk = 1; mSample = 1; end
      if (mC == mLen) begin
        if (!bus.RxBusy && !mFirst) begin
          mRun = 0; mIdleFirst = 1; mBitClk = 1;
        end else begin
          mIdx = (mIdx + 1) % 8; mFirst = 0; mC = 0; calcLens(mIdx);
          mBitClk = 0; mStart = 1;
        end
      end
    end
    for (int j = 7; j > 0; j--) begin rxH[j] = rxH[j-1]; rxV[j] = rxV[j-1]; end
    rxH[0] = bus.Rx;
    rxV[0] = reset;
  end

  // ---------------- compare, monitor, receiver stand-in ----------------
  always @(negedge MCLK) begin
    if (checkEn) begin
      check($sformatf("BITCLK@%0d", cyc),    bus.BITCLK,    mBitClk);
      check($sformatf("BitStart@%0d", cyc),  bus.BitStart,  mStart);
      check($sformatf("BitSample@%0d", cyc), bus.BitSample, mSample);
      check($sformatf("BRBusy@%0d", cyc),    bus.BRBusy,    mRun);
    end
    if (bus.BitStart === 1'b1)  startQ.push_back(cyc);
    if (bus.BitSample === 1'b1) sampQ.push_back(cyc);
  end

  // Raises RxBusy after the first sample, drops it once busyLimit bits started.
  always @(negedge MCLK) begin
    if (bus.BRBusy !== 1'b1) begin
      fs = 0;
      rxBusyDrv = 1'b0;
    end else begin
      if (bus.BitStart) fs++;
      if (bus.BitSample && fs < busyLimit) rxBusyDrv = 1'b1;
      if (fs >= busyLimit) rxBusyDrv = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic setCfg(input bit os, input int brw, input int brf, input int brs);
    bus.wUCOS16 = os;
    bus.wUCBRW  = 16'(brw);
    bus.wUCBRF  = 4'(brf);
    bus.wUCBRS  = 8'(brs);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (bus.BRBusy !== 1'b0 && n < budget) begin tick(1); n++; end
    check("idle_within_budget", bus.BRBusy, 0);
  endtask

  function automatic int gap(input int a, input int b);
    if (b < startQ.size() && a >= 0) return startQ[b] - startQ[a];
    return -1;
  endfunction

  // Drops Rx at a negedge; returns the cycle number of that negedge.
  task automatic frame(input int lim, output int t0, output int s0);
    busyLimit = lim;
    s0 = startQ.size();
    t0 = cyc;
    bus.Rx = 1'b0;
    tick(5);
    bus.Rx = 1'b1;
    waitIdle(3000);
    tick(3);
  endtask

  int t0, s0, p0;
  int exp2[9] = '{7, 6, 7, 6, 6, 6, 6, 6, 7};

  initial begin
    bus.Rx = 1'b1;
    setCfg(0, 6, 0, 0);
    for (int j = 0; j < 8; j++) begin rxH[j] = 1; rxV[j] = 0; end
    tick(3);
    checkEn = 1;
    // reset state
    check("reset_BITCLK", bus.BITCLK, 1);
    check("reset_BitStart", bus.BitStart, 0);
    check("reset_BitSample", bus.BitSample, 0);
    check("reset_BRBusy", bus.BRBusy, 0);
    reset = 1'b1;
    tick(6);

    // 1: LF, BRW=6
    p0 = sampQ.size();
    frame(3, t0, s0);
    check("t1_latency", startQ[s0] - t0, 3);
    check("t1_starts", startQ.size() - s0, 3);
    check("t1_period", gap(s0, s0 + 1), 6);
    check("t1_sample", sampQ[p0] - startQ[s0], 3);

    // 2: LF, BRS=05 modulation and idx wrap
    setCfg(0, 6, 0, 8'h05);
    p0 = sampQ.size();
    frame(10, t0, s0);
    for (int i = 0; i < 9; i++) check($sformatf("t2_bit%0d", i), gap(s0 + i, s0 + i + 1), exp2[i]);
    check("t2_sample", sampQ[p0] - startQ[s0], 3);

    // 3: OS16, BRW=1, BRF=0 then BRF=3
    setCfg(1, 1, 0, 0);
    p0 = sampQ.size();
    frame(2, t0, s0);
    check("t3_period", gap(s0, s0 + 1), 16);
    check("t3_sample", sampQ[p0] - startQ[s0], 8);
    setCfg(1, 1, 3, 0);
    p0 = sampQ.size();
    frame(2, t0, s0);
    check("t3f_period", gap(s0, s0 + 1), 19);
    check("t3f_sample", sampQ[p0] - startQ[s0], 11);

    // 4: RxBusy for 10 bits, then restart
    setCfg(0, 4, 0, 0);
    frame(10, t0, s0);
    check("t4_starts", startQ.size() - s0, 10);
    check("t4_BITCLK_idle", bus.BITCLK, 1);
    check("t4_BRBusy_idle", bus.BRBusy, 0);
    frame(2, t0, s0);
    check("t4_restart_latency", startQ[s0] - t0, 3);

    // 5: BRW changed mid-frame
    setCfg(0, 6, 0, 0);
    busyLimit = 4;
    s0 = startQ.size();
    bus.Rx = 1'b0;
    tick(5);
    bus.wUCBRW = 16'd10;
    bus.Rx = 1'b1;
    waitIdle(3000);
    tick(3);
    check("t5_p0", gap(s0, s0 + 1), 6);
    check("t5_p2", gap(s0 + 2, s0 + 3), 6);
    frame(2, t0, s0);
    check("t5_next", gap(s0, s0 + 1), 10);

    // 6: reset mid-bit, Rx held low afterwards
    setCfg(0, 6, 0, 0);
    busyLimit = 20;
    bus.Rx = 1'b0;
    tick(5);
    reset = 1'b0;
    tick(1);
    check("t6_BITCLK", bus.BITCLK, 1);
    check("t6_BRBusy", bus.BRBusy, 0);
    reset = 1'b1;
    s0 = startQ.size();
    tick(20);
    check("t6_no_start", startQ.size() - s0, 0);
    bus.Rx = 1'b1;
    tick(4);
    frame(2, t0, s0);
    check("t6_restart_latency", startQ[s0] - t0, 3);

    // 7: minimum periods
    setCfg(0, 0, 0, 0);
    p0 = sampQ.size();
    frame(3, t0, s0);
    check("t7_lf_min", gap(s0, s0 + 1), 2);
    check("t7_lf_sample", sampQ[p0] - startQ[s0], 1);
    setCfg(1, 0, 15, 8'hFF);
    p0 = sampQ.size();
    frame(2, t0, s0);
    check("t7_os_period", gap(s0, s0 + 1), 32);
    check("t7_os_sample", sampQ[p0] - startQ[s0], 16);

    tick(2);
    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end
endmodule
